// File: rtl/calc_controller.sv
// Single-digit calculator sequencer: operand/operator entry FSM, arithmetic,
// and a time-multiplexed 4-digit common-anode seven-segment display driver.
module calc_controller #(
    parameter int REFRESH_DIV = 100000,
    parameter int CNT_W       = 17
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] digit,
    input  logic       enter,
    input  logic       clear,
    input  logic [1:0] op_sel,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic [7:0] result,
    output logic       err,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_A    = 3'b000,
        S_B    = 3'b001,
        S_OP   = 3'b010,
        S_CALC = 3'b011,
        S_SHOW = 3'b100
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b1111110;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    function automatic logic [6:0] enc_digit(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    state_t           state_q, state_d;
    logic [3:0]       a_q, a_d;
    logic [3:0]       b_q, b_d;
    logic [1:0]       op_q, op_d;
    logic [7:0]       result_q, result_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [6:0]       seg_q, seg_d;
    logic [3:0]       an_q, an_d;

    logic [3:0] digit_latch;
    logic [7:0] a_ext, b_ext;
    logic [7:0] abs_val;
    logic [3:0] tens, units;
    logic [6:0] content;

    // The entry block can present a transient 10; never store it as an operand.
    assign digit_latch = (digit > 4'd9) ? 4'd0 : digit;
    assign a_ext       = {4'b0000, a_q};
    assign b_ext       = {4'b0000, b_q};

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        result_d = result_q;
        err_d    = err_q;
        if (clear) begin
            state_d  = S_A;
            a_d      = 4'd0;
            b_d      = 4'd0;
            op_d     = 2'd0;
            result_d = 8'd0;
            err_d    = 1'b0;
        end else begin
            case (state_q)
                S_A: if (enter) begin
                    a_d     = digit_latch;
                    state_d = S_B;
                end
                S_B: if (enter) begin
                    b_d     = digit_latch;
                    state_d = S_OP;
                end
                S_OP: if (enter) begin
                    op_d    = op_sel;
                    state_d = S_CALC;
                end
                S_CALC: begin
                    err_d = 1'b0;
                    case (op_q)
                        2'b00:   result_d = a_ext + b_ext;
                        2'b01:   result_d = a_ext - b_ext;
                        2'b10:   result_d = 8'(a_ext * b_ext);
                        default: begin
                            result_d = 8'd0;
                            err_d    = 1'b1;
                        end
                    endcase
                    state_d = S_SHOW;
                end
                S_SHOW: if (enter) begin
                    err_d   = 1'b0;
                    state_d = S_A;
                end
                default: state_d = S_A;
            endcase
        end
    end

    always_comb begin
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end else begin
            cnt_d = cnt_q + 1'b1;
            idx_d = idx_q;
        end
    end

    // Magnitude is at most 81, so a two-digit decimal split is sufficient.
    assign abs_val = result_q[7] ? (8'd0 - result_q) : result_q;
    assign tens    = 4'(abs_val / 8'd10);
    assign units   = 4'(abs_val % 8'd10);

    always_comb begin
        content = SEG_BLANK;
        case (state_q)
            S_A, S_B: begin
                if (idx_q == 2'd0) content = enc_digit(digit);
            end
            S_OP, S_CALC: begin
                if (idx_q == 2'd0) content = enc_digit({2'b00, op_sel});
            end
            S_SHOW: begin
                if (err_q) begin
                    content = SEG_MINUS;
                end else begin
                    case (idx_q)
                        2'd0:    content = enc_digit(units);
                        2'd1:    content = (tens != 4'd0) ? enc_digit(tens) : SEG_BLANK;
                        2'd2:    content = result_q[7] ? SEG_MINUS : SEG_BLANK;
                        default: content = SEG_BLANK;
                    endcase
                end
            end
            default: content = SEG_BLANK;
        endcase
    end

    assign seg_d = content;
    assign an_d  = ~(4'b0001 << idx_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_A;
            a_q      <= 4'd0;
            b_q      <= 4'd0;
            op_q     <= 2'd0;
            result_q <= 8'd0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            idx_q    <= 2'd0;
            seg_q    <= SEG_BLANK;
            an_q     <= 4'b1111;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            result_q <= result_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            seg_q    <= seg_d;
            an_q     <= an_d;
        end
    end

    assign seg    = seg_q;
    assign an     = an_q;
    assign result = result_q;
    assign err    = err_q;
    assign state  = state_q;

endmodule

// File: doc/calc_controller.md
Name: calc_controller

Overview:
Top-level sequencer for the single-digit calculator. Consumes the 0-9 digit value from the digit-entry block and already-conditioned enter/clear pulses. Steps operand A, operand B and the operator through an FSM, computes the result, and time-multiplexes a 4-digit common-anode seven-segment display. Sits between the button-conditioning blocks and the board display pins.

Parameters:
REFRESH_DIV, 100000, clocks per display digit slot (1 kHz per digit at 100 MHz); minimum 2
CNT_W, 17, refresh counter width; must satisfy 2^CNT_W >= REFRESH_DIV

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  asynchronous, active-low reset
digit  input  4  live digit from the entry block; valid range 0-9
enter  input  1  single-cycle pulse, already debounced and edge-detected
clear  input  1  single-cycle pulse, abort/clear
op_sel  input  2  00 add, 01 subtract (A-B), 10 multiply, 11 reserved
seg  output  7  segments {a..g}, active-low, registered
an  output  4  digit anodes, active-low one-hot, registered; an[0] = rightmost digit
result  output  8  signed two's-complement result, registered
err  output  1  reserved operator latched, registered
state  output  3  current FSM state encoding

Behaviour:
- Reset (reset=0, asynchronous): state=S_A, A=B=0, op=0, result=0, err=0, refresh counter=0, digit index=0, seg=7'b1111111, an=4'b1111.
- FSM encodings: S_A=000, S_B=001, S_OP=010, S_CALC=011, S_SHOW=100.
- Transitions:
  - S_A: enter latches digit into A, then S_B.
  - S_B: enter latches digit into B, then S_OP.
  - S_OP: enter latches op_sel, then S_CALC.
  - S_CALC: exactly one cycle; registers result and err, then S_SHOW. enter is ignored.
  - S_SHOW: enter clears err, then S_A. result holds until the next S_CALC or clear.
- clear in any state: next state S_A; A, B, op, result and err go to 0. clear has priority over a simultaneous enter.
- Digit latch rule: digit > 9 (the entry block's transient 10) is latched as 0.
- Arithmetic:
  - Operands are 4-bit unsigned, extended to 8-bit signed.
  - add: 0..18. sub: -9..9. mul: 0..81. No overflow is possible.
  - op 11: result=0, err=1.
- Display scheduler:
  - Refresh counter counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, digit index advances 0->1->2->3->0.
  - an and seg register the current index and its content every clock: 1-cycle latency.
  - First clock after reset release gives an=4'b1110.
- Digit content by state:
  - S_A/S_B: idx0 = encoded live digit (digit > 9 shows blank); idx1-3 blank.
  - S_OP: idx0 = op_sel value encoded as digit 0-3; others blank.
  - S_CALC: same as S_OP.
  - S_SHOW, err=0: idx0 = units of |result|; idx1 = tens of |result|, blank if zero; idx2 = minus if result < 0, else blank; idx3 blank.
  - S_SHOW, err=1: all four digits minus.
- Encoding: team table, 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100; blank=1111111; minus=1111110.
- Reset mid-operation: immediate return to reset values. Scan restarts at idx0.

Test Plan:
- Add, REFRESH_DIV=4: reset; digit=7 enter; digit=5 enter; op_sel=00 enter -> state=100, result=8'd12; scan shows idx0 0010010, idx1 1001111, idx2 and idx3 1111111.
- Subtract: A=3, B=8, op 01 -> result=8'hFB; idx0 0100100, idx1 blank, idx2 1111110, err=0.
- Multiply then restart: A=9, B=9, op 10 -> result=8'd81, idx1 0000000, idx0 1001111; enter -> state=000, result still 81, idx0 shows live digit.
- Reserved operator: A=2, B=2, op 11 -> err=1, result=0, all four digits 1111110; enter -> state=000, err=0.
- Clear priority and digit clamp: in S_OP pulse clear and enter together -> state=000, result=0; digit=10 enter in S_A -> A=0 (verify via A=0, B=4, add -> result=4).
- Scan and reset: REFRESH_DIV=4 -> an sequence 1110,1101,1011,0111,1110 with each value held 4 clocks; drop reset mid-slot -> an=1111 and seg=1111111 asynchronously, then 1110 on the first clock after release.
